cluster_shared_port_arb: RTL and testbench

Round-robin arbiter that shares one cluster memory port among `NumReq` core-side data requesters using the cluster `core_data_req_t`/`core_data_rsp_t` protocol. It sits between core data ports and a single TCDM/peripheral slave port, for example a shared FPU-side scratch port or an HWPE-side port with fewer memory ports than requesters. It issues at most one request per cycle, records the winner index for each granted request in an in-order ID FIFO, and routes each returning response to the requester that issued it.

---
 rtl/cluster_shared_port_arb_pkg.sv | 22 ++
 rtl/cluster_shared_port_arb_id_fifo.sv | 67 ++++++
 rtl/cluster_shared_port_arb.sv | 96 +++++++++
 tb/tb_cluster_shared_port_arb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cluster_shared_port_arb_pkg.sv
// Cluster core data port protocol types shared by the arbiter and its sub-modules.
package cluster_shared_port_arb_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = DataW / 8;

    typedef struct packed {
        logic             req;
        logic [AddrW-1:0] add;
        logic             we;
        logic [DataW-1:0] data;
        logic [BeW-1:0]   be;
    } core_data_req_t;

    typedef struct packed {
        logic             gnt;
        logic [DataW-1:0] r_data;
        logic             r_valid;
    } core_data_rsp_t;

endpackage

// File: rtl/cluster_shared_port_arb_id_fifo.sv
// In-order FIFO of requester indices for granted requests awaiting their response.
module cluster_shared_port_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Caller guarantees no push when full and no pop when empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_shared_port_arb.sv
// Round-robin arbiter sharing one cluster memory port among NumReq core data requesters,
// routing in-order responses back through a FIFO of winner indices.
module cluster_shared_port_arb
    import cluster_shared_port_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  core_data_req_t [NumReq-1:0] req_i,
    output core_data_rsp_t [NumReq-1:0] rsp_o,
    output core_data_req_t              mem_req_o,
    input  core_data_rsp_t              mem_rsp_i,
    output logic                        err_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            err_q, err_d;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] head_idx;
    logic            any_req;
    logic            fifo_full, fifo_empty;
    logic            hs, pop;
    int unsigned     cand;

    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumReq) cand = cand - NumReq;
            if (!any_req && req_i[IdxW'(cand)].req) begin
                any_req = 1'b1;
                win_idx = IdxW'(cand);
            end
        end
    end

    // Full is judged on the registered occupancy only, keeping r_valid off the req path.
    always_comb begin
        mem_req_o = '0;
        if (any_req) mem_req_o = req_i[win_idx];
        mem_req_o.req = any_req & ~fifo_full;
    end

    assign hs  = mem_req_o.req & mem_rsp_i.gnt;
    assign pop = mem_rsp_i.r_valid & ~fifo_empty;

    always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
        err_d = err_q | (mem_rsp_i.r_valid & fifo_empty);
    end

    always_comb begin
        rsp_o = '0;
        if (rst_ni) begin
            if (hs) rsp_o[win_idx].gnt = 1'b1;
            if (pop) begin
                rsp_o[head_idx].r_valid = 1'b1;
                rsp_o[head_idx].r_data  = mem_rsp_i.r_data;
            end
        end
    end

    cluster_shared_port_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (win_idx),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_cluster_shared_port_arb.sv
// Directed, table-driven bench for cluster_shared_port_arb (depth-2 and depth-1 instances).
module tb_cluster_shared_port_arb;
    import cluster_shared_port_arb_pkg::*;

    typedef struct {
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        int          win;
        logic        ereq;
        logic [3:0]  egnt;
        int          erv;
        logic        eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    core_data_req_t [3:0] req_i;
    core_data_rsp_t       mem_rsp_i;
    core_data_rsp_t [3:0] rsp_a, rsp_b;
    core_data_req_t       mreq_a, mreq_b;
    logic                 err_a, err_b;

    int checks = 0;
    int errors = 0;

    vec_t ta[24];
    vec_t tb_v[6];

    always #5 clk = ~clk;

    cluster_shared_port_arb #(.NumReq(4), .MaxOutstanding(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .rsp_o(rsp_a),
        .mem_req_o(mreq_a), .mem_rsp_i(mem_rsp_i), .err_o(err_a));

    cluster_shared_port_arb #(.NumReq(4), .MaxOutstanding(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .rsp_o(rsp_b),
        .mem_req_o(mreq_b), .mem_rsp_i(mem_rsp_i), .err_o(err_b));

    function automatic core_data_req_t lane(input int i, input logic r);
        core_data_req_t l;
        l.req  = r;
        l.add  = 32'h100 + 32'(i) * 32'd4;
        l.we   = i[0];
        l.data = 32'hD000_0000 + 32'(i);
        l.be   = 4'(1 << i);
        return l;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < 4; i++) req_i[i] = lane(i, v.req[i]);
        mem_rsp_i.gnt     = v.gnt;
        mem_rsp_i.r_valid = v.rv;
        mem_rsp_i.r_data  = v.rdata;
    endtask

    task automatic check(input string name, input int dsel, input vec_t v);
        core_data_req_t       em;
        core_data_rsp_t [3:0] er;
        core_data_req_t       am;
        core_data_rsp_t [3:0] ar;
        logic                 ae;
        em = '0;
        if (v.win >= 0) em = lane(v.win, 1'b1);
        em.req = v.ereq;
        er = '0;
        for (int i = 0; i < 4; i++) begin
            er[i].gnt = v.egnt[i];
            if (v.erv == i) begin
                er[i].r_valid = 1'b1;
                er[i].r_data  = v.rdata;
            end
        end
        am = (dsel == 0) ? mreq_a : mreq_b;
        ar = (dsel == 0) ? rsp_a : rsp_b;
        ae = (dsel == 0) ? err_a : err_b;
        checks++;
        if (am !== em) begin
            errors++;
            $display("FAIL %s mem_req got %h want %h", name, am, em);
        end
        checks++;
        if (ar !== er) begin
            errors++;
            $display("FAIL %s rsp got %h want %h", name, ar, er);
        end
        checks++;
        if (ae !== v.eerr) begin
            errors++;
            $display("FAIL %s err got %b want %b", name, ae, v.eerr);
        end
    endtask

    task automatic step(input string name, input int dsel, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(name, dsel, v);
    endtask

    task automatic idle_cycle(input logic rst);
        vec_t z;
        z = '{4'b0000, 1'b0, 1'b0, 32'h0, -1, 1'b0, 4'b0000, -1, 1'b0};
        @(negedge clk);
        rst_ni = rst;
        drive(z);
    endtask

    initial begin
        //         req      gnt   rv    rdata          win ereq  egnt     erv eerr
        ta[0]  = '{4'b0100, 1'b1, 1'b0, 32'h0,          2, 1'b1, 4'b0100, -1, 1'b0};
        ta[1]  = '{4'b0000, 1'b1, 1'b1, 32'hCAFE0002,  -1, 1'b0, 4'b0000,  2, 1'b0};
        ta[2]  = '{4'b1111, 1'b0, 1'b0, 32'h0,          3, 1'b1, 4'b0000, -1, 1'b0};
        ta[3]  = '{4'b1111, 1'b1, 1'b0, 32'h0,          3, 1'b1, 4'b1000, -1, 1'b0};
        ta[4]  = '{4'b1111, 1'b1, 1'b1, 32'hA3,         0, 1'b1, 4'b0001,  3, 1'b0};
        ta[5]  = '{4'b1111, 1'b1, 1'b1, 32'hA0,         1, 1'b1, 4'b0010,  0, 1'b0};
        ta[6]  = '{4'b1111, 1'b1, 1'b1, 32'hA1,         2, 1'b1, 4'b0100,  1, 1'b0};
        ta[7]  = '{4'b1111, 1'b1, 1'b1, 32'hA2,         3, 1'b1, 4'b1000,  2, 1'b0};
        ta[8]  = '{4'b1111, 1'b1, 1'b1, 32'hA3,         0, 1'b1, 4'b0001,  3, 1'b0};
        ta[9]  = '{4'b0000, 1'b1, 1'b1, 32'hA0,        -1, 1'b0, 4'b0000,  0, 1'b0};
        ta[10] = '{4'b1010, 1'b0, 1'b0, 32'h0,          1, 1'b1, 4'b0000, -1, 1'b0};
        ta[11] = '{4'b1010, 1'b0, 1'b0, 32'h0,          1, 1'b1, 4'b0000, -1, 1'b0};
        ta[12] = '{4'b1010, 1'b0, 1'b0, 32'h0,          1, 1'b1, 4'b0000, -1, 1'b0};
        ta[13] = '{4'b1010, 1'b1, 1'b0, 32'h0,          1, 1'b1, 4'b0010, -1, 1'b0};
        ta[14] = '{4'b1010, 1'b1, 1'b0, 32'h0,          3, 1'b1, 4'b1000, -1, 1'b0};
        ta[15] = '{4'b1010, 1'b1, 1'b0, 32'h0,          1, 1'b0, 4'b0000, -1, 1'b0};
        ta[16] = '{4'b1010, 1'b1, 1'b0, 32'h0,          1, 1'b0, 4'b0000, -1, 1'b0};
        ta[17] = '{4'b1010, 1'b1, 1'b1, 32'hB1,         1, 1'b0, 4'b0000,  1, 1'b0};
        ta[18] = '{4'b1010, 1'b1, 1'b0, 32'h0,          1, 1'b1, 4'b0010, -1, 1'b0};
        ta[19] = '{4'b1010, 1'b1, 1'b1, 32'hB3,         3, 1'b0, 4'b0000,  3, 1'b0};
        ta[20] = '{4'b0000, 1'b0, 1'b1, 32'hB1,        -1, 1'b0, 4'b0000,  1, 1'b0};
        ta[21] = '{4'b0000, 1'b0, 1'b1, 32'hEE,        -1, 1'b0, 4'b0000, -1, 1'b0};
        ta[22] = '{4'b0000, 1'b0, 1'b0, 32'h0,         -1, 1'b0, 4'b0000, -1, 1'b1};
        ta[23] = '{4'b0001, 1'b1, 1'b0, 32'h0,          0, 1'b1, 4'b0001, -1, 1'b1};

        tb_v[0] = '{4'b0011, 1'b1, 1'b0, 32'h0,         0, 1'b1, 4'b0001, -1, 1'b0};
        tb_v[1] = '{4'b0011, 1'b1, 1'b1, 32'hC0,        1, 1'b0, 4'b0000,  0, 1'b0};
        tb_v[2] = '{4'b0011, 1'b1, 1'b0, 32'h0,         1, 1'b1, 4'b0010, -1, 1'b0};
        tb_v[3] = '{4'b0011, 1'b1, 1'b1, 32'hC1,        0, 1'b0, 4'b0000,  1, 1'b0};
        tb_v[4] = '{4'b0011, 1'b1, 1'b0, 32'h0,         0, 1'b1, 4'b0001, -1, 1'b0};
        tb_v[5] = '{4'b0000, 1'b0, 1'b1, 32'hC0,       -1, 1'b0, 4'b0000,  0, 1'b0};

        // In reset: grants suppressed, request path still live.
        step("in_reset", 0, '{4'b0100, 1'b1, 1'b0, 32'h0, 2, 1'b1, 4'b0000, -1, 1'b0});
        idle_cycle(1'b1);

        for (int i = 0; i < 24; i++) step($sformatf("vecA%0d", i), 0, ta[i]);

        // Reset with one request outstanding and err set.
        @(negedge clk);
        rst_ni = 1'b0;
        drive('{4'b1111, 1'b1, 1'b0, 32'h0, 0, 1'b1, 4'b0000, -1, 1'b0});
        #1;
        check("mid_reset", 0, '{4'b1111, 1'b1, 1'b0, 32'h0, 0, 1'b1, 4'b0000, -1, 1'b0});
        @(negedge clk);
        rst_ni = 1'b1;
        drive('{4'b1111, 1'b0, 1'b0, 32'h0, 0, 1'b1, 4'b0000, -1, 1'b0});
        #1;
        check("post_reset_rr", 0, '{4'b1111, 1'b0, 1'b0, 32'h0, 0, 1'b1, 4'b0000, -1, 1'b0});
        step("late_rvalid", 0, '{4'b0000, 1'b0, 1'b1, 32'h77, -1, 1'b0, 4'b0000, -1, 1'b0});
        step("late_err", 0, '{4'b0000, 1'b0, 1'b0, 32'h0, -1, 1'b0, 4'b0000, -1, 1'b1});

        idle_cycle(1'b0);
        idle_cycle(1'b1);
        for (int i = 0; i < 6; i++) step($sformatf("vecB%0d", i), 1, tb_v[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
